rp_asg_sweep_ch: RTL and testbench

Parametrised next-generation ASG channel. Plays a table from internal RAM through a fractional phase pointer, then applies amplitude scaling and DC offset to produce DAC data.
- Sample width and table depth are parametrised.
- Adds a hardware linear frequency sweep: the pointer step ramps from a start value to a stop value during a burst.
- Sits between the ASG register bank (configuration and table writes) and the DAC output mux. One instance per DAC channel.

---
 rtl/rp_asg_pkg.sv | 26 ++
 rtl/rp_asg_scale.sv | 38 +++
 rtl/rp_asg_sweep_ch.sv | 169 ++++++++++++++++
 tb/tb_rp_asg_sweep_ch.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rp_asg_pkg.sv
// Shared types and helpers for the ASG channel family: FSM state encoding,
// output pipeline latency and a generic signed saturation function.
package rp_asg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAST = 2'd2
    } asg_state_t;

    // Pointer update to dac_o: addr reg, RAM read, select, mult, sum/saturate.
    localparam int PIPE_LAT = 5;

    // Clamp a sign-extended value to the signed range of a w-bit word.
    function automatic logic signed [63:0] sat_s(input logic signed [63:0] x,
                                                 input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi)      return hi;
        else if (x < lo) return lo;
        else             return x;
    endfunction

endpackage

// File: rtl/rp_asg_scale.sv
// Three-stage gain/offset/saturate for signed DAC samples; amp is unsigned
// with 2^(DW-1) as unity gain, dc is a signed offset.
module rp_asg_scale import rp_asg_pkg::*; #(
    parameter int DW = 14
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [DW-1:0] smp_i,
    input  logic [DW-1:0] amp_i,
    input  logic [DW-1:0] dc_i,
    output logic [DW-1:0] dac_o
);

    logic [DW-1:0]        smp_q;
    logic [DW:0]          mult_q;
    logic [DW-1:0]        dac_q;
    logic signed [DW+1:0] sum;

    // Two extra bits keep mult + dc free of overflow before clamping.
    always_comb begin
        sum = $signed({mult_q[DW], mult_q}) + $signed({{2{dc_i[DW-1]}}, dc_i});
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            smp_q  <= '0;
            mult_q <= '0;
            dac_q  <= '0;
        end else begin
            smp_q  <= smp_i;
            mult_q <= (DW+1)'(({{DW{smp_q[DW-1]}}, smp_q} * {{DW{1'b0}}, amp_i}) >> (DW-1));
            dac_q  <= DW'(sat_s({{(62-DW){sum[DW+1]}}, sum}, DW));
        end
    end

    assign dac_o = dac_q;

endmodule

// File: rtl/rp_asg_sweep_ch.sv
// ASG channel: table playback through a fractional pointer with a linear
// step sweep, scaled to DAC data. RP_ASG_SWEEP_BIDIR_EN enables ping-pong sweep.
module rp_asg_sweep_ch import rp_asg_pkg::*; #(
    parameter  int DW  = 14,
    parameter  int RSZ = 14,
    parameter  int FW  = 16,
    localparam int PW  = RSZ + FW
) (
    input  logic           dac_clk_i,
    input  logic           dac_rstn_i,
    input  logic           trig_i,
    input  logic           set_rst_i,
    input  logic           buf_we_i,
    input  logic [RSZ-1:0] buf_addr_i,
    input  logic [DW-1:0]  buf_wdata_i,
    output logic [DW-1:0]  buf_rdata_o,
    input  logic [PW-1:0]  set_size_i,
    input  logic [PW-1:0]  set_ofs_i,
    input  logic [PW-1:0]  set_step_start_i,
    input  logic [PW-1:0]  set_step_stop_i,
    input  logic [PW-1:0]  set_step_inc_i,
    input  logic [15:0]    set_sweep_div_i,
    input  logic [15:0]    set_ncyc_i,
    input  logic [DW-1:0]  set_amp_i,
    input  logic [DW-1:0]  set_dc_i,
    input  logic [DW-1:0]  set_first_i,
    input  logic [DW-1:0]  set_last_i,
    output logic [DW-1:0]  dac_o,
    output logic [PW-1:0]  step_o,
    output logic           busy_o,
    output logic           sweep_done_o
);

    asg_state_t     state_q, state_d;
    logic [PW-1:0]  pnt_q, pnt_d, step_q, step_d;
    logic [15:0]    cyc_q, cyc_d, div_q, div_d;
    logic           dir_q, dir_d, done_q, done_d;

    logic [RSZ-1:0] addr_q;
    logic [DW-1:0]  ram_q [2**RSZ];
    logic [DW-1:0]  rd_q, brd_q, smp_sel;
    asg_state_t     st1_q, st2_q;

    logic [PW:0]    npnt, up_sum, dn_lim;
    logic [PW-1:0]  hi, lo, tgt, nstep;
    logic           wrap, reach;

    always_comb begin
        state_d = state_q;
        pnt_d   = pnt_q;
        step_d  = step_q;
        cyc_d   = cyc_q;
        div_d   = div_q;
        dir_d   = dir_q;
        done_d  = 1'b0;

        npnt   = {1'b0, pnt_q} + {1'b0, step_q};
        wrap   = (step_q != '0) && (npnt >= {1'b0, set_size_i});
        // Sweep target is the endpoint in the current direction of travel.
        hi     = (set_step_start_i > set_step_stop_i) ? set_step_start_i : set_step_stop_i;
        lo     = (set_step_start_i > set_step_stop_i) ? set_step_stop_i  : set_step_start_i;
        tgt    = dir_q ? hi : lo;
        up_sum = {1'b0, step_q} + {1'b0, set_step_inc_i};
        dn_lim = {1'b0, tgt} + {1'b0, set_step_inc_i};
        reach  = dir_q ? (up_sum >= {1'b0, tgt}) : ({1'b0, step_q} <= dn_lim);
        nstep  = dir_q ? up_sum[PW-1:0] : (step_q - set_step_inc_i);

        if (set_rst_i) begin
            state_d = IDLE;
            pnt_d   = set_ofs_i;
        end else if (state_q != RUN) begin
            if (trig_i) begin
                state_d = RUN;
                pnt_d   = set_ofs_i;
                step_d  = set_step_start_i;
                cyc_d   = set_ncyc_i;
                div_d   = set_sweep_div_i;
                dir_d   = (set_step_start_i <= set_step_stop_i);
            end
        end else begin
            if (wrap) begin
                pnt_d = npnt[PW-1:0] - set_size_i;
                if (cyc_q != '0)   cyc_d   = cyc_q - 16'd1;
                if (cyc_q == 16'd1) state_d = LAST;
            end else begin
                pnt_d = npnt[PW-1:0];
            end

            if (div_q == '0) begin
                div_d = set_sweep_div_i;
                if (step_q != tgt) begin
                    step_d = reach ? tgt : nstep;
                    if (reach) begin
                        done_d = 1'b1;
`ifdef RP_ASG_SWEEP_BIDIR_EN
                        dir_d  = ~dir_q;
`endif
                    end
                end
            end else begin
                div_d = div_q - 16'd1;
            end
        end
    end

    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            state_q <= IDLE;
            pnt_q   <= '0;
            step_q  <= '0;
            cyc_q   <= '0;
            div_q   <= '0;
            dir_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pnt_q   <= pnt_d;
            step_q  <= step_d;
            cyc_q   <= cyc_d;
            div_q   <= div_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge dac_clk_i) begin
        if (buf_we_i) ram_q[buf_addr_i] <= buf_wdata_i;
    end

    // Reads are registered, so a same-cycle write to the read address returns old data.
    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            addr_q <= '0;
            rd_q   <= '0;
            brd_q  <= '0;
            st1_q  <= IDLE;
            st2_q  <= IDLE;
        end else begin
            addr_q <= pnt_q[PW-1:FW];
            rd_q   <= ram_q[addr_q];
            brd_q  <= ram_q[buf_addr_i];
            st1_q  <= state_q;
            st2_q  <= st1_q;
        end
    end

    always_comb begin
        case (st2_q)
            RUN:     smp_sel = rd_q;
            LAST:    smp_sel = set_last_i;
            default: smp_sel = set_first_i;
        endcase
    end

    rp_asg_scale #(.DW(DW)) u_scale (
        .clk_i  (dac_clk_i),
        .rst_ni (dac_rstn_i),
        .smp_i  (smp_sel),
        .amp_i  (set_amp_i),
        .dc_i   (set_dc_i),
        .dac_o  (dac_o)
    );

    assign buf_rdata_o  = brd_q;
    assign step_o       = step_q;
    assign busy_o       = (state_q == RUN);
    assign sweep_done_o = done_q;

endmodule

// File: tb/tb_rp_asg_sweep_ch.sv
// Self-checking bench for rp_asg_sweep_ch: randomized bursts and sweeps
// compared against a behavioural model of pointer, sweep and scaling rules.
module tb_rp_asg_sweep_ch;
    localparam int DW  = 14;
    localparam int RSZ = 14;
    localparam int FW  = 16;
    localparam int PW  = RSZ + FW;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           trig = 1'b0, set_rst = 1'b0, buf_we = 1'b0;
    logic [RSZ-1:0] buf_addr = '0;
    logic [DW-1:0]  buf_wdata = '0;
    logic [DW-1:0]  buf_rdata;
    logic [PW-1:0]  set_size = '0, set_ofs = '0, set_step_start = '0, set_step_stop = '0, set_step_inc = '0;
    logic [15:0]    set_sweep_div = '0, set_ncyc = '0;
    logic [DW-1:0]  set_amp = 14'h2000, set_dc = '0, set_first = '0, set_last = '0;
    logic [DW-1:0]  dac;
    logic [PW-1:0]  step;
    logic           busy, sweep_done;

    int total = 0;
    int bad = 0;
    logic [DW-1:0] tbl [16];

    always #5 clk = ~clk;

    rp_asg_sweep_ch #(.DW(DW), .RSZ(RSZ), .FW(FW)) dut (
        .dac_clk_i        (clk),
        .dac_rstn_i       (rst_n),
        .trig_i           (trig),
        .set_rst_i        (set_rst),
        .buf_we_i         (buf_we),
        .buf_addr_i       (buf_addr),
        .buf_wdata_i      (buf_wdata),
        .buf_rdata_o      (buf_rdata),
        .set_size_i       (set_size),
        .set_ofs_i        (set_ofs),
        .set_step_start_i (set_step_start),
        .set_step_stop_i  (set_step_stop),
        .set_step_inc_i   (set_step_inc),
        .set_sweep_div_i  (set_sweep_div),
        .set_ncyc_i       (set_ncyc),
        .set_amp_i        (set_amp),
        .set_dc_i         (set_dc),
        .set_first_i      (set_first),
        .set_last_i       (set_last),
        .dac_o            (dac),
        .step_o           (step),
        .busy_o           (busy),
        .sweep_done_o     (sweep_done)
    );

    function automatic logic [DW-1:0] scale_m(input logic [DW-1:0] smp, input logic [DW-1:0] amp,
                                              input logic [DW-1:0] dc);
        longint p, lim;
        p   = longint'($signed(smp)) * longint'(amp);
        p   = (p >>> (DW-1)) + longint'($signed(dc));
        lim = longint'(1) << (DW-1);
        if (p > lim - 1)   p = lim - 1;
        else if (p < -lim) p = -lim;
        return p[DW-1:0];
    endfunction

    // All tasks enter and leave just after a falling clock edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        buf_we = 1'b1; buf_addr = RSZ'(a); buf_wdata = d;
        @(negedge clk);
        buf_we = 1'b0;
    endtask

    task automatic pulse_trig();
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
    endtask

    task automatic pulse_rst();
        set_rst = 1'b1;
        @(negedge clk);
        set_rst = 1'b0;
    endtask

    task automatic test_reset();
        set_first = 14'h0123;
        rst_n = 1'b0;
        tick(3);
        total++; if (dac !== '0)        begin bad++; $display("FAIL reset_dac got=%h want=0", dac); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (step !== '0)       begin bad++; $display("FAIL reset_step got=%h want=0", step); end
        total++; if (sweep_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", sweep_done); end
        total++; if (buf_rdata !== '0)  begin bad++; $display("FAIL reset_rdata got=%h want=0", buf_rdata); end
        rst_n = 1'b1;
        tick(6);
        total++; if (dac !== 14'h0123) begin bad++; $display("FAIL idle_first got=%h want=0123", dac); end
    endtask

    task automatic test_readback();
        logic [DW-1:0] m [8];
        for (int i = 0; i < 8; i++) begin
            m[i] = DW'($urandom);
            wr(200 + i, m[i]);
        end
        for (int i = 0; i < 8; i++) begin
            buf_addr = RSZ'(200 + i);
            @(negedge clk);
            total++; if (buf_rdata !== m[i]) begin bad++; $display("FAIL rb_data i=%0d got=%h want=%h", i, buf_rdata, m[i]); end
        end
        buf_addr = RSZ'(203); buf_we = 1'b1; buf_wdata = ~m[3];
        @(negedge clk);
        buf_we = 1'b0;
        total++; if (buf_rdata !== m[3]) begin bad++; $display("FAIL rb_collide_old got=%h want=%h", buf_rdata, m[3]); end
        @(negedge clk);
        total++; if (buf_rdata !== ~m[3]) begin bad++; $display("FAIL rb_collide_new got=%h want=%h", buf_rdata, ~m[3]); end
    endtask

    task automatic test_scale();
        logic [DW-1:0] e;
        for (int i = 0; i < 12; i++) begin
            set_first = DW'($urandom);
            set_amp   = (i < 4) ? 14'h2000 : DW'($urandom);
            set_dc    = (i % 3 == 0) ? '0 : DW'($urandom);
            tick(4);
            e = scale_m(set_first, set_amp, set_dc);
            total++; if (dac !== e) begin bad++; $display("FAIL scale i=%0d got=%h want=%h", i, dac, e); end
        end
        set_amp = 14'h2000; set_dc = '0;
    endtask

    task automatic test_sat();
        set_size = PW'(1) << FW; set_ofs = '0; set_step_start = '0; set_step_stop = '0;
        set_step_inc = '0; set_ncyc = '0; set_sweep_div = '0;
        wr(0, 14'h1FFF);
        set_amp = 14'h2000; set_dc = 14'h1000;
        pulse_rst(); pulse_trig(); tick(6);
        total++; if (dac !== 14'h1FFF) begin bad++; $display("FAIL sat_pos got=%h want=1fff", dac); end
        total++; if (busy !== 1'b1)    begin bad++; $display("FAIL sat_busy got=%b want=1", busy); end
        pulse_rst();
        wr(0, 14'h2000);
        set_dc = 14'h3FFF;
        pulse_trig(); tick(6);
        total++; if (dac !== 14'h2000) begin bad++; $display("FAIL sat_neg got=%h want=2000", dac); end
        pulse_rst();
        set_dc = '0;
    endtask

    task automatic test_burst();
        int            len, cyc, n_end, st, m;
        int            st_m [400];
        longint        pn_m [400];
        longint        size, stp, ofs, p, np;
        logic [DW-1:0] e;
        for (int it = 0; it < 4; it++) begin
            if (it == 0) begin
                len = 8; stp = longint'(1) << FW; cyc = 2;
                set_amp = 14'h2000; set_dc = '0;
            end else begin
                len = $urandom_range(3, 16);
                stp = $urandom_range(1 << 14, (len << FW) - 1);
                cyc = $urandom_range(2, 3);
                set_amp = DW'($urandom_range(0, 16383));
                set_dc  = DW'($urandom);
            end
            size = longint'(len) << FW;
            ofs  = (it == 0) ? 0 : longint'($urandom_range(0, (len << FW) - 1));
            set_first = DW'($urandom); set_last = DW'($urandom);
            for (int i = 0; i < len; i++) begin
                tbl[i] = DW'($urandom);
                wr(i, tbl[i]);
            end
            set_size = PW'(size); set_ofs = PW'(ofs);
            set_step_start = PW'(stp); set_step_stop = PW'(stp); set_step_inc = '0;
            set_sweep_div = '0; set_ncyc = 16'(cyc);
            pulse_rst(); tick(6);

            p = ofs; st = 1; n_end = -1;
            for (int n = 0; n < 400; n++) begin
                st_m[n] = st; pn_m[n] = p;
                if (st == 1) begin
                    np = p + stp;
                    if (np >= size) begin
                        p = np - size;
                        if (cyc == 1) begin st = 2; n_end = n + 1; end
                        if (cyc != 0) cyc--;
                    end else begin
                        p = np;
                    end
                end
            end
            if (n_end < 0 || n_end > 390) n_end = 390;

            pulse_trig();
            for (int n = 0; n < n_end + 8; n++) begin
                m = n - 5;
                if (m < 0)                e = scale_m(set_first, set_amp, set_dc);
                else if (st_m[m] == 1)    e = scale_m(tbl[int'(pn_m[m] >> FW)], set_amp, set_dc);
                else                      e = scale_m(set_last, set_amp, set_dc);
                total++; if (dac !== e) begin bad++; $display("FAIL burst_dac it=%0d n=%0d got=%h want=%h", it, n, dac, e); end
                total++; if (busy !== (st_m[n] == 1)) begin bad++; $display("FAIL burst_busy it=%0d n=%0d got=%b want=%b", it, n, busy, st_m[n] == 1); end
                trig = (it > 0 && n == 3 && st_m[n] == 1);
                @(negedge clk);
            end
            trig = 1'b0;
        end
        set_amp = 14'h2000; set_dc = '0;
    endtask

    task automatic test_sweep();
        longint st0, sp, inc, val, hi, lo, tgt, nv;
        int     d, ncheck;
        bit     up, dn;
        for (int it = 0; it < 3; it++) begin
            if (it == 0) begin
                st0 = longint'(1) << FW; sp = longint'(4) << FW; inc = longint'(1) << FW;
                d = 9; ncheck = 80;
            end else begin
                st0 = longint'($urandom_range(0, 15)) << 12;
                sp  = longint'($urandom_range(0, 15)) << 12;
                inc = longint'($urandom_range(0, 5)) << 12;
                d = $urandom_range(0, 4); ncheck = 60;
            end
            set_size = PW'(16) << FW; set_ofs = '0; set_ncyc = '0;
            set_step_start = PW'(st0); set_step_stop = PW'(sp); set_step_inc = PW'(inc);
            set_sweep_div = 16'(d);
            pulse_rst(); tick(2); pulse_trig();
            val = st0; up = (st0 <= sp);
            hi = (st0 > sp) ? st0 : sp;
            lo = (st0 > sp) ? sp : st0;
            for (int n = 0; n < ncheck; n++) begin
                dn = 1'b0;
                if (n > 0 && n % (d + 1) == 0) begin
                    tgt = up ? hi : lo;
                    if (val != tgt) begin
                        if (up) nv = (val + inc > tgt) ? tgt : val + inc;
                        else    nv = (val - inc < tgt) ? tgt : val - inc;
                        if (nv == tgt) begin
                            dn = 1'b1;
`ifdef RP_ASG_SWEEP_BIDIR_EN
                            up = !up;
`endif
                        end
                        val = nv;
                    end
                end
                total++; if (step !== PW'(val)) begin bad++; $display("FAIL sweep_step it=%0d n=%0d got=%h want=%h", it, n, step, PW'(val)); end
                total++; if (sweep_done !== dn) begin bad++; $display("FAIL sweep_done it=%0d n=%0d got=%b want=%b", it, n, sweep_done, dn); end
                @(negedge clk);
            end
            pulse_rst();
        end
    endtask

    task automatic test_rst_trig();
        logic [DW-1:0] e;
        set_size = PW'(8) << FW; set_ofs = PW'(3) << FW; set_ncyc = '0;
        set_step_start = PW'(1) << FW; set_step_stop = PW'(1) << FW; set_step_inc = '0;
        set_first = DW'($urandom);
        for (int i = 0; i < 8; i++) begin
            tbl[i] = DW'($urandom);
            wr(i, tbl[i]);
        end
        pulse_rst(); tick(6); pulse_trig(); tick(10);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstpri_run got=%b want=1", busy); end
        set_rst = 1'b1; trig = 1'b1;
        @(negedge clk);
        set_rst = 1'b0; trig = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstpri_busy got=%b want=0", busy); end
        tick(5);
        e = scale_m(set_first, set_amp, set_dc);
        total++; if (dac !== e) begin bad++; $display("FAIL rstpri_first got=%h want=%h", dac, e); end
        pulse_trig(); tick(5);
        e = scale_m(tbl[3], set_amp, set_dc);
        total++; if (dac !== e) begin bad++; $display("FAIL rstpri_ofs got=%h want=%h", dac, e); end
        pulse_rst();
    endtask

    task automatic test_async_reset();
        logic [DW-1:0] e;
        set_ofs = '0; set_size = PW'(8) << FW; set_ncyc = '0;
        set_step_start = PW'(1) << FW; set_step_stop = PW'(1) << FW; set_step_inc = '0;
        set_first = DW'($urandom);
        pulse_rst(); tick(6); pulse_trig(); tick(8);
        #2 rst_n = 1'b0;
        #1;
        total++; if (dac !== '0)          begin bad++; $display("FAIL arst_dac got=%h want=0", dac); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL arst_busy got=%b want=0", busy); end
        total++; if (step !== '0)         begin bad++; $display("FAIL arst_step got=%h want=0", step); end
        total++; if (sweep_done !== 1'b0) begin bad++; $display("FAIL arst_done got=%b want=0", sweep_done); end
        total++; if (buf_rdata !== '0)    begin bad++; $display("FAIL arst_rdata got=%h want=0", buf_rdata); end
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        pulse_trig(); tick(5);
        e = scale_m(tbl[0], set_amp, set_dc);
        total++; if (dac !== e)  begin bad++; $display("FAIL arst_restart_dac got=%h want=%h", dac, e); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL arst_restart_busy got=%b want=1", busy); end
        total++; if (step !== PW'(1) << FW) begin bad++; $display("FAIL arst_restart_step got=%h want=%h", step, PW'(1) << FW); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_readback();
        test_scale();
        test_sat();
        test_burst();
        test_sweep();
        test_rst_trig();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
